// File: rtl/proc_pkg.sv
// Shared encodings for the sequencer and its companion ALU: widths, opcodes,
// FSM states and the instruction field layout.
package proc_pkg;

    localparam int DW   = 10;
    localparam int RW   = 3;
    localparam int NREG = 8;

    typedef enum logic [3:0] {
        OP_LOAD = 4'h0,
        OP_COPY = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_INV  = 4'h4,
        OP_FLP  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_LSL  = 4'h9,
        OP_LSR  = 4'hA,
        OP_ASR  = 4'hB
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDCP,
        ST_EXEC1,
        ST_EXEC2,
        ST_WB
    } state_e;

    typedef struct packed {
        logic [3:0]    fn;
        logic [RW-1:0] rx;
        logic [RW-1:0] ry;
    } instr_t;

    // LOAD, COPY and the illegal codes 1100-1111 finish in LDCP without the ALU.
    function automatic logic is_local_op(logic [3:0] fn);
        return (fn == OP_LOAD) || (fn == OP_COPY) || (fn >= 4'hC);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8x10 register file: one synchronous write port, three combinational read
// ports, and an asynchronous clear of every entry.
module reg_file #(
    parameter int DW   = proc_pkg::DW,
    parameter int NREG = proc_pkg::NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_x_i,
    input  logic [AW-1:0] raddr_y_i,
    input  logic [AW-1:0] raddr_dbg_i,
    output logic [DW-1:0] rdata_x_o,
    output logic [DW-1:0] rdata_y_o,
    output logic [DW-1:0] rdata_dbg_o
);

    logic [DW-1:0] regs_q [NREG];

    // NOTE: the array sits in the async reset branch because every register must
    // read zero straight after Reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_x_o   = regs_q[raddr_x_i];
    assign rdata_y_o   = regs_q[raddr_y_i];
    assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control stage upstream of the 10-bit ALU: latches one instruction,
// sequences operand fetch, ALU capture and write-back into the register file.
module alu_sequencer #(
    parameter int DW   = proc_pkg::DW,
    parameter int NREG = proc_pkg::NREG
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Run,
    input  logic [DW-1:0]          Instr,
    input  logic [DW-1:0]          Din,
    output logic                   Busy,
    output logic                   Done,
    output logic [DW-1:0]          ALU_A,
    output logic [DW-1:0]          ALU_B,
    output logic [3:0]             ALU_FN,
    input  logic [DW-1:0]          ALU_Q,
    input  logic [proc_pkg::RW-1:0] DbgSel,
    output logic [DW-1:0]          DbgData
);

    import proc_pkg::*;

    state_e        state_q;
    instr_t        ir_q;
    instr_t        instr_in;
    logic [DW-1:0] din_q;
    logic [DW-1:0] areg_q;
    logic [DW-1:0] g_q;

    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_x;
    logic [DW-1:0] rd_y;

    assign instr_in = instr_t'(Instr);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            din_q   <= '0;
            areg_q  <= '0;
            g_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Run) begin
                        ir_q    <= instr_in;
                        din_q   <= Din;
                        state_q <= is_local_op(instr_in.fn) ? ST_LDCP : ST_EXEC1;
                    end
                end
                ST_LDCP:  state_q <= ST_IDLE;
                ST_EXEC1: begin
                    areg_q  <= rd_x;
                    state_q <= ST_EXEC2;
                end
                ST_EXEC2: begin
                    g_q     <= ALU_Q;
                    state_q <= ST_WB;
                end
                ST_WB:    state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        we    = 1'b0;
        wdata = g_q;
        if (state_q == ST_LDCP) begin
            we    = (ir_q.fn == OP_LOAD) || (ir_q.fn == OP_COPY);
            wdata = (ir_q.fn == OP_LOAD) ? din_q : rd_y;
        end else if (state_q == ST_WB) begin
            we = 1'b1;
        end
    end

    reg_file #(
        .DW   (DW),
        .NREG (NREG)
    ) u_reg_file (
        .Clock       (Clock),
        .Reset       (Reset),
        .we_i        (we),
        .waddr_i     (ir_q.rx),
        .wdata_i     (wdata),
        .raddr_x_i   (ir_q.rx),
        .raddr_y_i   (ir_q.ry),
        .raddr_dbg_i (DbgSel),
        .rdata_x_o   (rd_x),
        .rdata_y_o   (rd_y),
        .rdata_dbg_o (DbgData)
    );

    assign Busy   = (state_q != ST_IDLE);
    assign Done   = (state_q == ST_LDCP) || (state_q == ST_WB);
    assign ALU_A  = areg_q;
    assign ALU_B  = rd_y;
    assign ALU_FN = ir_q.fn;

endmodule
